// File: rtl/pll_rst_pkg.sv
// Shared types for the PLL reset supervisor: FSM state encoding and a small
// constant helper used for elaboration-time sizing checks.
package pll_rst_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, asynchronously cleared to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL supervisor: pulses PLL RESET, qualifies the synchronised LOCK for a
// stable window, retries on lock timeout and drives one system reset.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int CNT_W          = 17,
    parameter int RETRY_W        = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               sys_resetn,
    output logic               locked,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int MAX_CNT = max3(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    if (PLL_RST_CYCLES < 2 || STABLE_CYCLES < 2 || LOCK_TIMEOUT < 2) begin : g_bad_cycles
        $error("pll_reset_ctrl: cycle parameters must all be >= 2");
    end
    if ($clog2(MAX_CNT) > CNT_W) begin : g_bad_cnt_w
        $error("pll_reset_ctrl: CNT_W too small for the largest cycle count");
    end

    logic               w_lock_s;
    pll_state_e         r_state;
    pll_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               r_pll_reset;
    logic               r_sys_resetn;
    logic               r_locked;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_PLL_RST;
            r_cnt   <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == PRST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            // A lock arriving on the timeout cycle is taken rather than retried.
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = '0;
                    if (r_retry != '1) begin
                        w_retry_nxt = r_retry + RETRY_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            // Lock loss in RUN gives the PLL a full timeout window before any reset.
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pll_reset  <= 1'b1;
            r_sys_resetn <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_pll_reset  <= (w_state_nxt == ST_PLL_RST);
            r_sys_resetn <= (w_state_nxt == ST_RUN);
            r_locked     <= (w_state_nxt == ST_RUN);
        end
    end

    assign pll_reset  = r_pll_reset;
    assign sys_resetn = r_sys_resetn;
    assign locked     = r_locked;
    assign retry_cnt  = r_retry;
    assign state_dbg  = r_state;

endmodule
